// File: rtl/phy_tx_par2serial_if.sv
// Byte-in / serial-out bus between the TX lane mux and the parallel-to-serial stage.
// master = byte source and serial observer, slave = serializer.
interface phy_tx_par2serial_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              serial_out;
  logic              serial_valid;
  logic              frame_start;
  logic              overflow;

  modport master (
    output data_in, valid_in,
    input  ready_out, serial_out, serial_valid, frame_start, overflow
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, serial_out, serial_valid, frame_start, overflow
  );
endinterface

// File: rtl/phy_tx_par2serial.sv
// Byte FIFO feeding a free-running MSB-first serializer; idle pattern when the FIFO is empty.
// Define PHY_TX_PARITY_EN to append an even-parity bit (9-bit frames).
module phy_tx_par2serial #(
  parameter int             DATA_W     = 8,
  parameter logic [7:0]     IDLE_BYTE  = 8'hBC,
  parameter int             FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  phy_tx_par2serial_if.slave bus
);
`ifdef PHY_TX_PARITY_EN
  localparam int BITS = DATA_W + 1;
`else
  localparam int BITS = DATA_W;
`endif
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BITS - 1);

  logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;

  logic [CNT_W-1:0]  cnt_reg;
  logic [BITS-1:0]   shift_reg;
  logic              serial_out_reg;
  logic              serial_valid_reg;
  logic              frame_start_reg;
  logic              overflow_reg;

  logic              full;
  logic              push;
  logic              load;
  logic              pop;
  logic [DATA_W-1:0] load_byte;
  logic [BITS-1:0]   frame_w;

  // ready_out comes from the registered count only, so a pop on the same edge
  // never opens a slot for a push in a full FIFO.
  assign full = (count_reg == DEPTH_C);
  assign push = bus.valid_in && !full;
  assign load = (cnt_reg == '0);
  assign pop  = load && (count_reg != '0);

  always_comb begin
    load_byte = IDLE_BYTE;
    if (pop) begin
      load_byte = mem_reg[rd_ptr_reg];
    end
  end

`ifdef PHY_TX_PARITY_EN
  assign frame_w = {load_byte, ^load_byte};
`else
  assign frame_w = load_byte;
`endif

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      cnt_reg          <= '0;
      shift_reg        <= '0;
      serial_out_reg   <= 1'b0;
      serial_valid_reg <= 1'b0;
      frame_start_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (bus.valid_in && full) begin
        overflow_reg <= 1'b1;
      end
      if (load) begin
        serial_out_reg   <= frame_w[BITS-1];
        shift_reg        <= frame_w << 1;
        serial_valid_reg <= pop;
        frame_start_reg  <= 1'b1;
        cnt_reg          <= CNT_W'(1);
      end else begin
        serial_out_reg  <= shift_reg[BITS-1];
        shift_reg       <= shift_reg << 1;
        frame_start_reg <= 1'b0;
        cnt_reg         <= (cnt_reg == LAST_C) ? '0 : cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.ready_out    = !full;
  assign bus.serial_out   = serial_out_reg;
  assign bus.serial_valid = serial_valid_reg;
  assign bus.frame_start  = frame_start_reg;
  assign bus.overflow     = overflow_reg;
endmodule

// File: tb/tb_phy_tx_par2serial.sv
// Scoreboard bench for phy_tx_par2serial: stimulus queues expected bytes,
// a negedge monitor reassembles frames and checks them against the queue.
module tb_phy_tx_par2serial;
`ifdef PHY_TX_PARITY_EN
  localparam int BITS = 9;
`else
  localparam int BITS = 8;
`endif
  localparam logic [7:0] IDLE = 8'hBC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  phy_tx_par2serial_if bus ();

  phy_tx_par2serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic       rst_sampled = 1'b1;
  int         idx = 0;
  logic       frame_valid = 1'b0;
  logic [8:0] bits = '0;
  logic [7:0] exp_byte;

  function automatic logic [8:0] frame_of(input logic [7:0] b);
    if (BITS == 9) return {b, ^b};
    return {1'b0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: reset value checks, frame_start cadence, frame reassembly.
  always @(posedge clk) rst_sampled <= reset;

  always @(negedge clk) begin
    if (rst_sampled) begin
      check("rst_serial_out", bus.serial_out, 0);
      check("rst_serial_valid", bus.serial_valid, 0);
      check("rst_frame_start", bus.frame_start, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_ready_out", bus.ready_out, 1);
      idx = 0;
      exp_q.delete();
    end else begin
      check("frame_start_cadence", bus.frame_start, (idx == 0));
      if (idx == 0) begin
        frame_valid = bus.serial_valid;
        bits = {8'b0, bus.serial_out};
      end else begin
        check("serial_valid_hold", bus.serial_valid, frame_valid);
        bits = {bits[7:0], bus.serial_out};
      end
      if (idx == BITS - 1) begin
        if (frame_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_data_frame actual=%0h required=idle", bits);
          end else begin
            exp_byte = exp_q.pop_front();
            $display("rx data frame %03h expected byte %02h", bits, exp_byte);
            check("data_frame", bits, frame_of(exp_byte));
          end
        end else begin
          check("idle_frame", bits, frame_of(IDLE));
        end
        idx = 0;
      end else begin
        idx++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame_start();
    for (int i = 0; i < 4 * BITS; i++) begin
      @(negedge clk);
      if (bus.frame_start) return;
    end
    checks++;
    errors++;
    $display("FAIL frame_start_timeout actual=none required=frame_start");
  endtask

  task automatic drive_push(input logic [7:0] b, input logic accept);
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    if (accept) exp_q.push_back(b);
    $display("tx push %02h expect_accept=%0d", b, accept);
  endtask

  task automatic idle_in();
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
  endtask

  logic [7:0] singles [3] = '{8'hA5, 8'h03, 8'h80};
  logic [7:0] b;

  initial begin
    idle_in();
    reset = 1'b1;
    // Test 1: reset for 3 clocks, then free-running idle frames
    step(3);
    reset = 1'b0;
    step(3 * BITS);

    // Test 2/6: single byte with best-case latency (push one edge before LOAD)
    for (int s = 0; s < 3; s++) begin
      b = singles[s];
      wait_frame_start();
      step(BITS - 2);
      drive_push(b, 1'b1);
      step(1);
      idle_in();
      step(1);
      check("latency_frame_start", bus.frame_start, 1);
      check("latency_serial_valid", bus.serial_valid, 1);
      check("latency_msb", bus.serial_out, b[7]);
      step(3 * BITS);
    end

    // Test 5: push coincides with LOAD on empty FIFO
    wait_frame_start();
    step(BITS - 1);
    drive_push(8'h5A, 1'b1);
    step(1);
    idle_in();
    check("coincide_frame_start", bus.frame_start, 1);
    check("coincide_idle", bus.serial_valid, 0);
    step(BITS);
    check("coincide_next_frame_start", bus.frame_start, 1);
    check("coincide_next_valid", bus.serial_valid, 1);
    step(3 * BITS);

    // Test 3: burst of 6 right after a LOAD; last two dropped
    wait_frame_start();
    for (int i = 0; i < 6; i++) begin
      drive_push(8'(i + 1), (i < 4));
      step(1);
      check("burst_ready_out", bus.ready_out, (i < 3));
      check("burst_overflow", bus.overflow, (i >= 4));
    end
    idle_in();
    step(BITS - 6);
    for (int k = 0; k < 5; k++) begin
      check("burst_frame_start", bus.frame_start, 1);
      check("burst_back_to_back", bus.serial_valid, (k < 4));
      step(BITS);
    end
    check("overflow_sticky", bus.overflow, 1);

    // Test 4: reset during bit 4 of a 0xFF frame with two bytes queued
    wait_frame_start();
    drive_push(8'hFF, 1'b1);
    step(1);
    drive_push(8'h11, 1'b1);
    step(1);
    drive_push(8'h22, 1'b1);
    step(1);
    idle_in();
    step(BITS);
    check("pre_reset_in_data_frame", bus.serial_valid, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    check("post_reset_frame_start", bus.frame_start, 1);
    check("post_reset_idle", bus.serial_valid, 0);
    check("post_reset_overflow", bus.overflow, 0);
    step(4 * BITS);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
